// File: rtl/avg_pkg.sv
// Shared constants and FSM state encoding for the two-channel moving-average scheduler.
package avg_pkg;
  localparam int DEF_WIDTH  = 8;
  localparam int DEF_DEPTH  = 8;
  localparam int LOG2_DEPTH = $clog2(DEF_DEPTH);
  localparam int ACC_W      = DEF_WIDTH + LOG2_DEPTH;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACC  = 2'd1,
    ST_DONE = 2'd2
  } state_t;
endpackage

// File: rtl/avg_window.sv
// One channel's sliding sample window: circular write port, combinational indexed read.
module avg_window #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_en_i,
  input  logic [WIDTH-1:0]         wr_data_i,
  input  logic [$clog2(DEPTH)-1:0] rd_idx_i,
  output logic [WIDTH-1:0]         rd_data_o
);
  localparam int LG = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [LG-1:0]    wr_ptr_q;

  // DEPTH is a power of two, so the pointer wraps naturally and overwrites the oldest sample
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (wr_en_i) begin
      mem_q[wr_ptr_q] <= wr_data_i;
      wr_ptr_q        <= wr_ptr_q + LG'(1);
    end
  end

  assign rd_data_o = mem_q[rd_idx_i];
endmodule

// File: rtl/avg_sched.sv
// Round-robin scheduler feeding two per-channel windows into one serially sequenced adder.
//   state | meaning
//   IDLE  | arbitrate, accept one sample into the granted window
//   ACC   | sum DEPTH taps of the granted window, one per cycle
//   DONE  | hold result until the consumer takes it
module avg_sched
  import avg_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic             clk,
  input  logic             rs,
  input  logic [1:0]       in_valid,
  input  logic [WIDTH-1:0] in_data0,
  input  logic [WIDTH-1:0] in_data1,
  output logic [1:0]       in_ready,
  output logic             out_valid,
  output logic             out_ch,
  output logic [WIDTH-1:0] out_avg,
  input  logic             out_ready
);
  localparam int LG = $clog2(DEPTH);
  localparam int AW = WIDTH + LG;

  state_t           state_q, state_d;
  logic [AW-1:0]    acc_q, acc_d;
  logic [LG-1:0]    idx_q, idx_d;
  logic             cur_ch_q, cur_ch_d;
  logic             last_grant_q, last_grant_d;
  logic             out_valid_q, out_valid_d;
  logic             out_ch_q, out_ch_d;
  logic [WIDTH-1:0] out_avg_q, out_avg_d;

  logic [1:0]       grant;
  logic             hs;
  logic [WIDTH-1:0] tap0, tap1, tap;
  logic [AW-1:0]    sum;

  avg_window #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_win0 (
    .clk       (clk),
    .rst_n     (rs),
    .wr_en_i   (in_valid[0] & in_ready[0]),
    .wr_data_i (in_data0),
    .rd_idx_i  (idx_q),
    .rd_data_o (tap0)
  );

  avg_window #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_win1 (
    .clk       (clk),
    .rst_n     (rs),
    .wr_en_i   (in_valid[1] & in_ready[1]),
    .wr_data_i (in_data1),
    .rd_idx_i  (idx_q),
    .rd_data_o (tap1)
  );

  // On a tie the channel that did not win last time gets the grant
  always_comb begin
    grant = 2'b00;
    case (in_valid)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = last_grant_q ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
  end

  assign in_ready = (state_q == ST_IDLE) ? grant : 2'b00;
  assign hs       = |(in_valid & in_ready);
  assign tap      = cur_ch_q ? tap1 : tap0;
  assign sum      = acc_q + AW'(tap);

  always_comb begin
    state_d      = state_q;
    acc_d        = acc_q;
    idx_d        = idx_q;
    cur_ch_d     = cur_ch_q;
    last_grant_d = last_grant_q;
    out_valid_d  = out_valid_q;
    out_ch_d     = out_ch_q;
    out_avg_d    = out_avg_q;
    case (state_q)
      ST_IDLE: begin
        if (hs) begin
          cur_ch_d     = in_ready[1];
          last_grant_d = in_ready[1];
          acc_d        = '0;
          idx_d        = '0;
          state_d      = ST_ACC;
        end
      end
      ST_ACC: begin
        acc_d = sum;
        idx_d = idx_q + LG'(1);
        // Final tap folds straight into the result; truncating shift by LG
        if (idx_q == LG'(DEPTH - 1)) begin
          out_avg_d   = sum[AW-1:LG];
          out_ch_d    = cur_ch_q;
          out_valid_d = 1'b1;
          state_d     = ST_DONE;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rs) begin
    if (!rs) begin
      state_q      <= ST_IDLE;
      acc_q        <= '0;
      idx_q        <= '0;
      cur_ch_q     <= 1'b0;
      last_grant_q <= 1'b1;
      out_valid_q  <= 1'b0;
      out_ch_q     <= 1'b0;
      out_avg_q    <= '0;
    end else begin
      state_q      <= state_d;
      acc_q        <= acc_d;
      idx_q        <= idx_d;
      cur_ch_q     <= cur_ch_d;
      last_grant_q <= last_grant_d;
      out_valid_q  <= out_valid_d;
      out_ch_q     <= out_ch_d;
      out_avg_q    <= out_avg_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_ch    = out_ch_q;
  assign out_avg   = out_avg_q;
endmodule

// File: tb/tb_avg_sched.sv
// Directed bench for avg_sched: reset, single pushes, window wrap, ties, back-pressure, aborts.
module tb_avg_sched;
  logic       clk = 1'b0;
  logic       rs;
  logic [1:0] in_valid;
  logic [7:0] in_data0, in_data1;
  logic [1:0] in_ready;
  logic       out_valid, out_ch, out_ready;
  logic [7:0] out_avg;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  avg_sched #(.WIDTH(8), .DEPTH(8)) dut (
    .clk       (clk),
    .rs        (rs),
    .in_valid  (in_valid),
    .in_data0  (in_data0),
    .in_data1  (in_data1),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_ch    (out_ch),
    .out_avg   (out_avg),
    .out_ready (out_ready)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_rst_outputs(input string tag);
    chk({tag, "_out_valid"}, 32'(out_valid), 0);
    chk({tag, "_out_ch"},    32'(out_ch), 0);
    chk({tag, "_out_avg"},   32'(out_avg), 0);
    chk({tag, "_in_ready"},  32'(in_ready), 0);
  endtask

  // Called at a negedge with the FSM in IDLE; holds in_valid through ACC/DONE.
  task automatic xact(input logic [1:0] vld, input logic [7:0] d0, input logic [7:0] d1,
                      input logic g, input logic [7:0] avg, input int bp);
    logic [1:0] nxt;
    in_valid = vld;
    in_data0 = d0;
    in_data1 = d1;
    #1;
    chk("grant", 32'(in_ready), g ? 2 : 1);
    @(negedge clk);
    for (int k = 0; k < 8; k++) begin
      chk("acc_in_ready", 32'(in_ready), 0);
      chk("acc_out_valid", 32'(out_valid), 0);
      @(negedge clk);
    end
    chk("out_valid", 32'(out_valid), 1);
    chk("out_ch", 32'(out_ch), 32'(g));
    chk("out_avg", 32'(out_avg), 32'(avg));
    for (int k = 0; k < bp; k++) begin
      @(negedge clk);
      chk("bp_out_valid", 32'(out_valid), 1);
      chk("bp_out_ch", 32'(out_ch), 32'(g));
      chk("bp_out_avg", 32'(out_avg), 32'(avg));
      chk("bp_in_ready", 32'(in_ready), 0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("release_out_valid", 32'(out_valid), 0);
    nxt = (vld == 2'b11) ? (g ? 2'b01 : 2'b10) : vld;
    chk("next_in_ready", 32'(in_ready), 32'(nxt));
    in_valid = 2'b00;
  endtask

  initial begin
    rs        = 1'b0;
    in_valid  = 2'b00;
    in_data0  = 8'd0;
    in_data1  = 8'd0;
    out_ready = 1'b0;
    #1;
    chk_rst_outputs("reset");
    @(negedge clk);
    @(negedge clk);
    rs = 1'b1;
    @(negedge clk);

    // single sample 80 on ch0 -> 10
    xact(2'b01, 8'd80, 8'd0, 1'b0, 8'd10, 0);

    // abort in the middle of ACC
    in_valid = 2'b01;
    in_data0 = 8'd50;
    @(negedge clk);
    in_valid = 2'b00;
    @(negedge clk);
    @(negedge clk);
    rs = 1'b0;
    #1;
    chk_rst_outputs("midacc_reset");
    @(negedge clk);
    chk_rst_outputs("midacc_reset_hold");
    rs = 1'b1;
    @(negedge clk);
    // tie right after reset goes to ch0; cleared window gives 8>>3 = 1
    xact(2'b11, 8'd8, 8'd16, 1'b0, 8'd1, 0);

    // truncation on an empty window: 7>>3 = 0
    rs = 1'b0;
    @(negedge clk);
    rs = 1'b1;
    @(negedge clk);
    xact(2'b01, 8'd7, 8'd0, 1'b0, 8'd0, 0);

    // fill ch1 with 16s (2,4,..,16), then wrap with 255 -> 45
    for (int i = 1; i <= 8; i++)
      xact(2'b10, 8'd0, 8'd16, 1'b1, 8'(2 * i), (i == 4) ? 5 : 0);
    xact(2'b10, 8'd0, 8'd255, 1'b1, 8'd45, 0);

    // continuous ties: ch0 [7,40]->5, ch1 [255,100,16x6]->56, ch0 ->10, ch1 ->66
    xact(2'b11, 8'd40, 8'd100, 1'b0, 8'd5, 0);
    xact(2'b11, 8'd40, 8'd100, 1'b1, 8'd56, 0);
    xact(2'b11, 8'd40, 8'd100, 1'b0, 8'd10, 0);
    xact(2'b11, 8'd40, 8'd100, 1'b1, 8'd66, 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
